// File: rtl/seg_display_monitor_if.sv
// Display pin bundle plus the decoded view of what the display shows.
//   an      : anode selects, active-low, an[3] = leftmost digit
//   seg     : segments, active-low, seg[6] = g .. seg[0] = a
//   dp      : decimal point, active-low
//   code_o  : committed glyph code per digit, digit i at [5i+4:5i]
//   dp_o    : committed decimal point per digit, 1 = lit
//   lit     : 1 = digit refreshed recently enough to be considered on
//   update  : one-cycle pulse when a digit's code_o, dp_o or lit changes
//   unknown : 1 while any lit digit shows an undecodable pattern
// There is no flow control: the pins are sampled whenever they are stable,
// and the outputs are level/pulse indications that cannot be back-pressured.
// master = whoever drives the pins and observes the result; slave = monitor.
interface seg_display_monitor_if;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [19:0] code_o;
   logic [3:0]  dp_o;
   logic [3:0]  lit;
   logic [3:0]  update;
   logic        unknown;

   modport master (output an, seg, dp,
                   input  code_o, dp_o, lit, update, unknown);
   modport slave  (input  an, seg, dp,
                   output code_o, dp_o, lit, update, unknown);
endinterface

// File: rtl/seg_display_monitor.sv
// Receive-side monitor for a multiplexed 4-digit seven-segment display.
// Synchronizes the an/seg/dp pins, waits for them to settle, decodes the
// segment pattern to a glyph code and commits it per digit once the same
// glyph has been seen on enough consecutive refreshes. Digits that stop
// being refreshed are declared dark after TIMEOUT cycles.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low reset
//   bus   : pin inputs and decoded outputs (see seg_display_monitor_if)
module seg_display_monitor #(
   parameter int SETTLE     = 4,
   parameter int STABLE_CNT = 3,
   parameter int TIMEOUT    = 1048576
) (
   input logic                   clk,
   input logic                   reset,
   seg_display_monitor_if.slave  bus
);

   localparam int             AW        = $clog2(TIMEOUT + 1);
   localparam logic [7:0]     SETTLE_M1 = 8'(SETTLE - 1);
   localparam logic [2:0]     STABLE_V  = 3'(STABLE_CNT);
   localparam logic [AW-1:0]  TMO_V     = AW'(TIMEOUT);
   localparam logic [AW-1:0]  TMO_M1    = AW'(TIMEOUT - 1);
   localparam logic [4:0]     BLANK     = 5'h12;

   // Two-flop synchronizers, then one more register to detect changes.
   logic [3:0]    an_m, an_s, an_q;
   logic [6:0]    seg_m, seg_s, seg_q;
   logic          dp_m, dp_s, dp_q;
   logic [7:0]    settle_cnt;

   logic [4:0]    cand_code [4];
   logic [3:0]    cand_dp;
   logic [2:0]    match     [4];
   logic [AW-1:0] age       [4];

   logic [19:0]   code_q;
   logic [3:0]    dp_oq, lit_q, update_q;

   logic          change, sample;
   logic [4:0]    dec;
   logic          dp_lit;
   logic [3:0]    sel, same, commit, tmo;
   logic [2:0]    match_nxt [4];
   logic          unknown_c;

   function automatic logic [4:0] decode(input logic [6:0] s);
      case (s)
         7'h40: decode = 5'h00;
         7'h79: decode = 5'h01;
         7'h24: decode = 5'h02;
         7'h30: decode = 5'h03;
         7'h19: decode = 5'h04;
         7'h12: decode = 5'h05;
         7'h02: decode = 5'h06;
         7'h78: decode = 5'h07;
         7'h00: decode = 5'h08;
         7'h10: decode = 5'h09;
         7'h08: decode = 5'h0A;
         7'h03: decode = 5'h0B;
         7'h46: decode = 5'h0C;
         7'h21: decode = 5'h0D;
         7'h06: decode = 5'h0E;
         7'h0E: decode = 5'h0F;
         7'h47: decode = 5'h10;
         7'h41: decode = 5'h11;
         7'h7F: decode = 5'h12;
         7'h3F: decode = 5'h13;
         default: decode = 5'h1F;
      endcase
   endfunction

   always_comb begin
      change = ({an_s, seg_s, dp_s} != {an_q, seg_q, dp_q});
      // Fires on the one cycle the settle counter steps onto SETTLE, so a
      // long stable window yields exactly one sample.
      sample = !change && (settle_cnt == SETTLE_M1) && (an_q != 4'hF);
      dec    = decode(seg_q);
      dp_lit = ~dp_q;
      for (int i = 0; i < 4; i++) begin
         sel[i]  = sample && !an_q[i];
         same[i] = ({cand_code[i], cand_dp[i]} == {dec, dp_lit});
         if (!same[i])
            match_nxt[i] = 3'd1;
         else if (match[i] == STABLE_V)
            match_nxt[i] = match[i];
         else
            match_nxt[i] = match[i] + 3'd1;
         // Commit only on the transition onto STABLE_CNT, not while saturated.
         commit[i] = sel[i] && (match_nxt[i] == STABLE_V) &&
                     !(same[i] && (match[i] == STABLE_V));
         // A sample on the same cycle overrides the timeout.
         tmo[i]    = !sel[i] && (age[i] == TMO_M1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         an_m       <= 4'hF;
         an_s       <= 4'hF;
         an_q       <= 4'hF;
         seg_m      <= 7'h7F;
         seg_s      <= 7'h7F;
         seg_q      <= 7'h7F;
         dp_m       <= 1'b1;
         dp_s       <= 1'b1;
         dp_q       <= 1'b1;
         settle_cnt <= '0;
         code_q     <= {4{BLANK}};
         dp_oq      <= '0;
         lit_q      <= '0;
         update_q   <= '0;
         cand_dp    <= '0;
         for (int i = 0; i < 4; i++) begin
            cand_code[i] <= '0;
            match[i]     <= '0;
            age[i]       <= '0;
         end
      end else begin
         an_m  <= bus.an;
         an_s  <= an_m;
         an_q  <= an_s;
         seg_m <= bus.seg;
         seg_s <= seg_m;
         seg_q <= seg_s;
         dp_m  <= bus.dp;
         dp_s  <= dp_m;
         dp_q  <= dp_s;

         if (change)
            settle_cnt <= '0;
         else if (settle_cnt != 8'hFF)
            settle_cnt <= settle_cnt + 8'd1;

         update_q <= '0;
         for (int i = 0; i < 4; i++) begin
            if (sel[i]) begin
               cand_code[i] <= dec;
               cand_dp[i]   <= dp_lit;
               match[i]     <= match_nxt[i];
               age[i]       <= '0;
               if (commit[i]) begin
                  code_q[5*i +: 5] <= dec;
                  dp_oq[i]         <= dp_lit;
                  lit_q[i]         <= 1'b1;
                  update_q[i]      <= (code_q[5*i +: 5] != dec) ||
                                      (dp_oq[i] != dp_lit) || !lit_q[i];
               end
            end else begin
               // Age holds at TIMEOUT until the digit is sampled again.
               if (age[i] != TMO_V)
                  age[i] <= age[i] + 1'b1;
               if (tmo[i]) begin
                  code_q[5*i +: 5] <= BLANK;
                  dp_oq[i]         <= 1'b0;
                  lit_q[i]         <= 1'b0;
                  match[i]         <= '0;
                  update_q[i]      <= lit_q[i];
               end
            end
         end
      end
   end

   always_comb begin
      unknown_c = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (lit_q[i] && (code_q[5*i +: 5] == 5'h1F))
            unknown_c = 1'b1;
      end
   end

   assign bus.code_o  = code_q;
   assign bus.dp_o    = dp_oq;
   assign bus.lit     = lit_q;
   assign bus.update  = update_q;
   assign bus.unknown = unknown_c;

endmodule
